// File: rtl/ahbl_stream_loader.sv
// ahbl_stream_loader: packs an 8-bit stream into little-endian words written as AHB-Lite single writes
module ahbl_stream_loader #(
  parameter int LEN_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len_bytes,
  output logic             busy,
  output logic             done,
  input  logic [7:0]       s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic             HWRITE,
  output logic [31:0]      HWDATA,
  input  logic             HREADY
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, pack_q, pack_d, word_q, word_d, hwdata_q, hwdata_d, merged;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [1:0] lane_q, lane_d;
  logic pend_q, pend_d, dph_q, dph_d, last_b, fills, take, aacc;
  always_comb begin
    last_b = rem_q == LEN_W'(1);
    fills = last_b || lane_q == 2'd3;
    aacc = pend_q && HREADY;
    // a completing byte may enter only if the pending word leaves on this same edge
    s_tready = state_q == RUN && rem_q != '0 && !(fills && pend_q && !HREADY);
    take = s_tvalid && s_tready;
    merged = pack_q | (32'(s_tdata) << {lane_q, 3'b000});
    state_d = state_q;
    addr_d = addr_q;
    pack_d = pack_q;
    word_d = word_q;
    hwdata_d = hwdata_q;
    rem_d = rem_q;
    lane_d = lane_q;
    pend_d = pend_q;
    dph_d = HREADY ? pend_q : dph_q;
    if (aacc) begin
      hwdata_d = word_q;
      addr_d = addr_q + 32'd4;
      pend_d = 1'b0;
    end
    if (take) begin
      rem_d = rem_q - LEN_W'(1);
      pack_d = fills ? '0 : merged;
      lane_d = fills ? 2'd0 : lane_q + 2'd1;
      word_d = fills ? merged : word_q;
      pend_d = fills ? 1'b1 : pend_d;
    end
    if (state_q == IDLE && start) begin
      addr_d = {base_addr[31:2], 2'b00};
      rem_d = len_bytes;
      pack_d = '0;
      lane_d = 2'd0;
      state_d = len_bytes == '0 ? DONE : RUN;
    end
    if (state_q == RUN && take && last_b) state_d = DRAIN;
    if (state_q == DRAIN && !pend_q && dph_q && HREADY) state_d = DONE;
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= IDLE;
      addr_q <= '0;
      pack_q <= '0;
      word_q <= '0;
      hwdata_q <= '0;
      rem_q <= '0;
      lane_q <= '0;
      pend_q <= 1'b0;
      dph_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      pack_q <= pack_d;
      word_q <= word_d;
      hwdata_q <= hwdata_d;
      rem_q <= rem_d;
      lane_q <= lane_d;
      pend_q <= pend_d;
      dph_q <= dph_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign HADDR = addr_q;
  assign HTRANS = pend_q ? 2'b10 : 2'b00;
  assign HSIZE = 3'b010;
  assign HBURST = 3'b000;
  assign HWRITE = 1'b1;
  assign HWDATA = hwdata_q;
endmodule

// File: tb/tb_ahbl_stream_loader.sv
// tb_ahbl_stream_loader: table vectors, hand sequences and random transfers against a word-list model
module tb_ahbl_stream_loader;
  logic HCLK = 0, HRESET = 1, start = 0, s_tvalid = 0, HREADY = 1;
  logic [31:0] base_addr = 0;
  logic [15:0] len_bytes = 0;
  logic [7:0] s_tdata = 0;
  logic busy, done, s_tready, HWRITE;
  logic [31:0] HADDR, HWDATA;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE, HBURST;
  int checks = 0, fails = 0;
  int cyc = 0, hr_mode = 1, done_cnt = 0, last_dcyc = 0, acc_cnt = 0, idx = 0;
  logic [7:0] bq[$];
  logic [31:0] got_a[$], got_d[$];
  bit dph = 0, prv_ok = 0, p_hr = 1;
  logic [31:0] p_addr = 0, p_wdata = 0;
  logic [1:0] p_trans = 0;

  typedef struct {
    logic [31:0] base;
    int len;
    int hr;
    bit poke;
    logic [31:0] first_a;
    logic [31:0] last_w;
    int nw;
  } vec_t;
  vec_t tbl[6];

  always #5 HCLK = ~HCLK;

  ahbl_stream_loader #(.LEN_W(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .base_addr(base_addr), .len_bytes(len_bytes),
    .busy(busy), .done(done), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge HCLK) begin
    cyc++;
    if (HRESET) begin
      dph = 0;
      prv_ok = 0;
    end else begin
      if (prv_ok && !p_hr) begin
        chk("hold_hwdata", HWDATA, p_wdata);
        if (p_trans == 2'b10) begin
          chk("hold_haddr", HADDR, p_addr);
          chk("hold_htrans", 32'(HTRANS), 32'(p_trans));
        end
      end
      if (dph && HREADY) begin
        got_d.push_back(HWDATA);
        last_dcyc = cyc;
      end
      if (HREADY) dph = HTRANS == 2'b10;
      if (HTRANS == 2'b10 && HREADY) got_a.push_back(HADDR);
      if (s_tvalid && s_tready) acc_cnt++;
      if (done) done_cnt++;
      p_addr = HADDR;
      p_wdata = HWDATA;
      p_trans = HTRANS;
      p_hr = HREADY;
      prv_ok = 1;
    end
  end

  initial forever begin
    @(posedge HCLK);
    #1;
    HREADY = hr_mode == 2 ? ($urandom_range(0, 2) != 0) : (hr_mode == 1);
  end

  task automatic nsamp();
    @(negedge HCLK);
    #1;
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic start_xfer(logic [31:0] b, int len);
    got_a.delete();
    got_d.delete();
    done_cnt = 0;
    acc_cnt = 0;
    idx = 0;
    base_addr = b;
    len_bytes = 16'(len);
    start = 1;
    step();
    start = 0;
  endtask

  task automatic feed(int budget, bit poke, bit vmode);
    int n = 0;
    bit a;
    while (idx < bq.size() && n < budget) begin
      s_tvalid = vmode ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_tdata = bq[idx];
      if (poke && n == 3) begin
        start = 1;
        base_addr = 32'hDEAD0000;
        len_bytes = 16'd3;
      end
      nsamp();
      a = s_tvalid && s_tready;
      step();
      start = 0;
      if (a) idx++;
      n++;
    end
    s_tvalid = 0;
  endtask

  task automatic finish_xfer(string tag, logic [31:0] b, int budget);
    int n = 0;
    int nw = (bq.size() + 3) / 4;
    logic [31:0] w;
    do begin
      nsamp();
      n++;
    end while (!done && n < budget);
    chk({tag, " done_seen"}, 32'(done), 32'd1);
    if (done) begin
      chk({tag, " busy_in_done"}, 32'(busy), 32'd1);
      chk({tag, " nwrites"}, got_d.size(), nw);
      chk({tag, " naddr"}, got_a.size(), nw);
      chk({tag, " bytes_taken"}, acc_cnt, bq.size());
      if (nw > 0) chk({tag, " done_latency"}, cyc, last_dcyc + 1);
      for (int i = 0; i < nw; i++) begin
        w = 0;
        for (int k = 0; k < 4; k++) if (4 * i + k < bq.size()) w[8*k+:8] = bq[4*i+k];
        chk({tag, " addr"}, i < got_a.size() ? got_a[i] : 32'hx, (b & ~32'h3) + 32'(4 * i));
        chk({tag, " data"}, i < got_d.size() ? got_d[i] : 32'hx, w);
      end
    end
    step();
    nsamp();
    chk({tag, " done_after"}, 32'(done), 32'd0);
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
    chk({tag, " done_pulses"}, done_cnt, 1);
    step();
  endtask

  initial begin
    tbl[0] = '{32'h100, 8, 1, 1, 32'h100, 32'h88776655, 2};
    tbl[1] = '{32'h100, 5, 1, 0, 32'h100, 32'h00000055, 2};
    tbl[2] = '{32'h203, 3, 2, 1, 32'h200, 32'h00332211, 1};
    tbl[3] = '{32'hFFFFFFFC, 9, 2, 0, 32'hFFFFFFFC, 32'h00000099, 3};
    tbl[4] = '{32'h40, 12, 2, 0, 32'h40, 32'hCCBBAA99, 3};
    tbl[5] = '{32'h300, 0, 1, 0, 32'h0, 32'h0, 0};
    repeat (2) step();
    nsamp();
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst tready", 32'(s_tready), 0);
    chk("rst htrans", 32'(HTRANS), 0);
    chk("rst haddr", HADDR, 0);
    chk("rst hwdata", HWDATA, 0);
    chk("hsize", 32'(HSIZE), 32'd2);
    chk("hburst", 32'(HBURST), 32'd0);
    chk("hwrite", 32'(HWRITE), 32'd1);
    step();
    HRESET = 0;
    step();

    foreach (tbl[v]) begin
      bq.delete();
      for (int i = 0; i < tbl[v].len; i++) bq.push_back(8'(8'h11 * (i + 1)));
      hr_mode = tbl[v].hr;
      step();
      start_xfer(tbl[v].base, tbl[v].len);
      feed(400, tbl[v].poke, 1);
      finish_xfer($sformatf("vec%0d", v), tbl[v].base, 300);
      chk($sformatf("vec%0d count", v), got_d.size(), tbl[v].nw);
      if (tbl[v].nw > 0) begin
        chk($sformatf("vec%0d first_addr", v), got_a.size() > 0 ? got_a[0] : 32'hx, tbl[v].first_a);
        chk($sformatf("vec%0d last_word", v), got_d.size() > 0 ? got_d[got_d.size()-1] : 32'hx, tbl[v].last_w);
      end
    end

    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
    hr_mode = 0;
    step();
    start_xfer(32'h500, 8);
    feed(20, 0, 0);
    nsamp();
    chk("stall bytes_taken", idx, 7);
    chk("stall tready", 32'(s_tready), 0);
    chk("stall htrans", 32'(HTRANS), 32'd2);
    chk("stall haddr", HADDR, 32'h500);
    step();
    hr_mode = 2;
    feed(400, 0, 1);
    finish_xfer("stall", 32'h500, 300);

    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
    hr_mode = 1;
    start_xfer(32'h600, 8);
    feed(5, 0, 0);
    HRESET = 1;
    step();
    nsamp();
    chk("mrst htrans", 32'(HTRANS), 0);
    chk("mrst busy", 32'(busy), 0);
    chk("mrst tready", 32'(s_tready), 0);
    chk("mrst haddr", HADDR, 0);
    chk("mrst hwdata", HWDATA, 0);
    step();
    HRESET = 0;
    repeat (3) step();
    nsamp();
    chk("mrst no_done", done_cnt, 0);
    step();
    bq.delete();
    for (int i = 0; i < 6; i++) bq.push_back(8'($urandom));
    start_xfer(32'h700, 6);
    feed(400, 0, 1);
    finish_xfer("after_rst", 32'h700, 300);

    for (int r = 0; r < 20; r++) begin
      logic [31:0] b;
      int len;
      b = $urandom;
      len = $urandom_range(1, 40);
      bq.delete();
      for (int i = 0; i < len; i++) bq.push_back(8'($urandom));
      hr_mode = 2;
      start_xfer(b, len);
      feed(1000, r % 4 == 0, 1);
      finish_xfer($sformatf("rnd%0d", r), b, 500);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
